// File: rtl/sdram_init_sequencer.sv
// Power-up initialisation sequencer for an SDR SDRAM: powerup NOP delay, PRECHARGE ALL,
// a burst of AUTO REFRESH commands and LOAD MODE, then hands the bus over via config_done.
module sdram_init_sequencer #(
  parameter int                    POWERUP_CYCLES = 10000,
  parameter int                    TRP_CYCLES     = 2,
  parameter int                    TRFC_CYCLES    = 7,
  parameter int                    TMRD_CYCLES    = 2,
  parameter int                    REFRESH_COUNT  = 8,
  parameter int                    ADDR_WIDTH     = 13,
  parameter logic [ADDR_WIDTH-1:0] MODE_REG       = ADDR_WIDTH'('h020)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  s_cke,
  output logic                  s_cs_n,
  output logic                  s_ras_n,
  output logic                  s_cas_n,
  output logic                  s_we_n,
  output logic [1:0]            s_ba,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [1:0]            s_dqm,
  output logic                  init_busy,
  output logic                  config_done
);

  localparam int MAX_PT  = (POWERUP_CYCLES > TRP_CYCLES) ? POWERUP_CYCLES : TRP_CYCLES;
  localparam int MAX_FM  = (TRFC_CYCLES > TMRD_CYCLES) ? TRFC_CYCLES : TMRD_CYCLES;
  localparam int MAX_ALL = (MAX_PT > MAX_FM) ? MAX_PT : MAX_FM;
  localparam int CW_RAW  = $clog2(MAX_ALL);
  localparam int CW      = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int RW_RAW  = $clog2(REFRESH_COUNT + 1);
  localparam int RW      = (RW_RAW < 1) ? 1 : RW_RAW;

  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_COUNT);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_PRECHARGE,
    ST_WAIT_TRP,
    ST_REFRESH,
    ST_WAIT_TRFC,
    ST_LOAD_MODE,
    ST_WAIT_TMRD,
    ST_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [RW-1:0]         ref_reg, ref_next, ref_inc;
  logic [3:0]            cmd_reg, cmd_next;
  logic [1:0]            ba_reg, ba_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [1:0]            dqm_reg, dqm_next;
  logic                  done_reg, done_next;
  logic                  cke_reg;

  // Command states put their command on the bus at the edge they are in; wait states
  // hold NOP and leave on the edge their counter steps from 1 to 0.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ref_next   = ref_reg;
    ref_inc    = ref_reg + RW'(1);
    cmd_next   = CMD_NOP;
    ba_next    = 2'b00;
    addr_next  = '0;
    dqm_next   = 2'b11;
    done_next  = 1'b0;
    case (state_reg)
      ST_POWERUP: begin
        if (count_reg == '0) state_next = ST_PRECHARGE;
        else                 count_next = count_reg - CW'(1);
      end
      ST_PRECHARGE: begin
        cmd_next      = CMD_PRE;
        addr_next[10] = 1'b1;
        if (TRP_CYCLES == 1) begin
          state_next = ST_REFRESH;
        end else begin
          state_next = ST_WAIT_TRP;
          count_next = CW'(TRP_CYCLES - 1);
        end
      end
      ST_WAIT_TRP: begin
        if (count_reg <= CW'(1)) state_next = ST_REFRESH;
        else                     count_next = count_reg - CW'(1);
      end
      ST_REFRESH: begin
        cmd_next = CMD_REF;
        ref_next = ref_inc;
        if (TRFC_CYCLES == 1) begin
          state_next = (ref_inc == REF_LAST) ? ST_LOAD_MODE : ST_REFRESH;
        end else begin
          state_next = ST_WAIT_TRFC;
          count_next = CW'(TRFC_CYCLES - 1);
        end
      end
      ST_WAIT_TRFC: begin
        if (count_reg <= CW'(1)) state_next = (ref_reg == REF_LAST) ? ST_LOAD_MODE : ST_REFRESH;
        else                     count_next = count_reg - CW'(1);
      end
      ST_LOAD_MODE: begin
        cmd_next  = CMD_LMR;
        addr_next = MODE_REG;
        if (TMRD_CYCLES == 1) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_WAIT_TMRD;
          count_next = CW'(TMRD_CYCLES - 1);
        end
      end
      ST_WAIT_TMRD: begin
        if (count_reg <= CW'(1)) state_next = ST_DONE;
        else                     count_next = count_reg - CW'(1);
      end
      ST_DONE: begin
        dqm_next  = 2'b00;
        done_next = 1'b1;
      end
      default: state_next = ST_POWERUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_POWERUP;
      count_reg <= CW'(POWERUP_CYCLES - 1);
      ref_reg   <= '0;
      cke_reg   <= 1'b0;
      cmd_reg   <= CMD_NOP;
      ba_reg    <= 2'b00;
      addr_reg  <= '0;
      dqm_reg   <= 2'b11;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ref_reg   <= ref_next;
      cke_reg   <= 1'b1;
      cmd_reg   <= cmd_next;
      ba_reg    <= ba_next;
      addr_reg  <= addr_next;
      dqm_reg   <= dqm_next;
      done_reg  <= done_next;
    end
  end

  assign s_cke                              = cke_reg;
  assign {s_cs_n, s_ras_n, s_cas_n, s_we_n} = cmd_reg;
  assign s_ba                               = ba_reg;
  assign s_addr                             = addr_reg;
  assign s_dqm                              = dqm_reg;
  assign config_done                        = done_reg;
  assign init_busy                          = ~done_reg;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Bench for sdram_init_sequencer: three parameter sets, per-edge comparison against
// tables of expected command edges, plus reset-in-sequence and reset-in-DONE runs.
module tb_sdram_init_sequencer;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  // {cke, cmd[3:0], ba[1:0], addr[12:0], dqm[1:0], busy, done}
  localparam logic [23:0] RESET_VEC = {1'b0, 4'b0111, 2'b00, 13'h0000, 2'b11, 1'b1, 1'b0};

  typedef struct {
    int          edge_n;
    logic [3:0]  cmd;
    logic [12:0] addr;
  } vec_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b000;
  always #5 clk = ~clk;

  logic        a_cke, a_cs, a_ras, a_cas, a_we, a_busy, a_done;
  logic [1:0]  a_ba, a_dqm;
  logic [12:0] a_addr;
  logic        b_cke, b_cs, b_ras, b_cas, b_we, b_busy, b_done;
  logic [1:0]  b_ba, b_dqm;
  logic [12:0] b_addr;
  logic        c_cke, c_cs, c_ras, c_cas, c_we, c_busy, c_done;
  logic [1:0]  c_ba, c_dqm;
  logic [12:0] c_addr;

  sdram_init_sequencer #(
    .POWERUP_CYCLES(20), .TRP_CYCLES(2), .TRFC_CYCLES(7), .TMRD_CYCLES(2), .REFRESH_COUNT(2)
  ) dut_a (
    .clk(clk), .reset_n(rst_n[0]), .s_cke(a_cke), .s_cs_n(a_cs), .s_ras_n(a_ras),
    .s_cas_n(a_cas), .s_we_n(a_we), .s_ba(a_ba), .s_addr(a_addr), .s_dqm(a_dqm),
    .init_busy(a_busy), .config_done(a_done)
  );

  sdram_init_sequencer #(
    .POWERUP_CYCLES(1), .TRP_CYCLES(1), .TRFC_CYCLES(1), .TMRD_CYCLES(1), .REFRESH_COUNT(1)
  ) dut_b (
    .clk(clk), .reset_n(rst_n[1]), .s_cke(b_cke), .s_cs_n(b_cs), .s_ras_n(b_ras),
    .s_cas_n(b_cas), .s_we_n(b_we), .s_ba(b_ba), .s_addr(b_addr), .s_dqm(b_dqm),
    .init_busy(b_busy), .config_done(b_done)
  );

  sdram_init_sequencer dut_c (
    .clk(clk), .reset_n(rst_n[2]), .s_cke(c_cke), .s_cs_n(c_cs), .s_ras_n(c_ras),
    .s_cas_n(c_cas), .s_we_n(c_we), .s_ba(c_ba), .s_addr(c_addr), .s_dqm(c_dqm),
    .init_busy(c_busy), .config_done(c_done)
  );

  logic [23:0] obs_a, obs_b, obs_c;
  assign obs_a = {a_cke, a_cs, a_ras, a_cas, a_we, a_ba, a_addr, a_dqm, a_busy, a_done};
  assign obs_b = {b_cke, b_cs, b_ras, b_cas, b_we, b_ba, b_addr, b_dqm, b_busy, b_done};
  assign obs_c = {c_cke, c_cs, c_ras, c_cas, c_we, c_ba, c_addr, c_dqm, c_busy, c_done};

  vec_t tbl[$];
  int   sel = 0;
  int   done_edge = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [23:0] cur_obs();
    case (sel)
      0:       return obs_a;
      1:       return obs_b;
      default: return obs_c;
    endcase
  endfunction

  // Expected outputs at a given edge after release: NOP unless the table lists a command.
  function automatic logic [23:0] exp_at(int e);
    logic [3:0]  c = NOP;
    logic [12:0] a = 13'h0000;
    logic        d;
    foreach (tbl[i]) begin
      if (tbl[i].edge_n == e) begin
        c = tbl[i].cmd;
        a = tbl[i].addr;
      end
    end
    d = (e >= done_edge);
    return {1'b1, c, 2'b00, a, (d ? 2'b00 : 2'b11), ~d, d};
  endfunction

  task automatic check(input string name, input int e, input logic [23:0] exp);
    logic [23:0] got;
    got = cur_obs();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s edge %0d: got %h expected %h", name, e, got, exp);
    end else if (exp[22:19] != NOP) begin
      $display("vec %s edge %0d cmd %b addr %h ok", name, e, exp[22:19], exp[16:4]);
    end
  endtask

  // Holds reset for n edges, checking reset values after each, then releases.
  task automatic reset_cycles(input string name, input int n);
    rst_n[sel] = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check(name, 0, RESET_VEC);
    end
    rst_n[sel] = 1'b1;
  endtask

  task automatic run_edges(input string name, input int first, input int last);
    for (int e = first; e <= last; e++) begin
      @(posedge clk); #1;
      check(name, e, exp_at(e));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;

    // Set A: POWERUP=20, TRP=2, TRFC=7, REFRESH=2, TMRD=2
    sel = 0;
    done_edge = 39;
    tbl.delete();
    tbl.push_back('{edge_n: 21, cmd: PRE, addr: 13'h0400});
    tbl.push_back('{edge_n: 23, cmd: REF, addr: 13'h0000});
    tbl.push_back('{edge_n: 30, cmd: REF, addr: 13'h0000});
    tbl.push_back('{edge_n: 37, cmd: LMR, addr: 13'h0020});
    reset_cycles("a_reset", 2);
    run_edges("a_seq", 1, 45);
    reset_cycles("a_done_reset", 3);
    run_edges("a_after_done_reset", 1, 45);
    reset_cycles("a_pre_reset", 1);
    run_edges("a_before_mid", 1, 29);
    reset_cycles("a_mid_reset", 3);
    run_edges("a_restart", 1, 45);

    // Set B: every timing parameter 1, one refresh
    sel = 1;
    done_edge = 5;
    tbl.delete();
    tbl.push_back('{edge_n: 2, cmd: PRE, addr: 13'h0400});
    tbl.push_back('{edge_n: 3, cmd: REF, addr: 13'h0000});
    tbl.push_back('{edge_n: 4, cmd: LMR, addr: 13'h0020});
    reset_cycles("b_reset", 2);
    run_edges("b_seq", 1, 8);

    // Set C: default parameters
    sel = 2;
    done_edge = 10061;
    tbl.delete();
    tbl.push_back('{edge_n: 10001, cmd: PRE, addr: 13'h0400});
    for (int i = 0; i < 8; i++) tbl.push_back('{edge_n: 10003 + 7 * i, cmd: REF, addr: 13'h0000});
    tbl.push_back('{edge_n: 10059, cmd: LMR, addr: 13'h0020});
    reset_cycles("c_reset", 2);
    run_edges("c_seq", 1, 10065);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_init_sequencer.md
Name: sdram_init_sequencer

Overview:
- Power-up initialisation sequencer for the single-data-rate SDRAM controller.
- Holds the SDRAM in NOP for the power-up delay, then issues PRECHARGE ALL, REFRESH_COUNT AUTO REFRESH commands and LOAD MODE REGISTER, each with its programmed spacing.
- Then asserts config_done, which the controller uses to take ownership of the command bus and which the SDRAM config status register reports to software.
- Pure timing/command generator; it has no data path.

Parameters:
- POWERUP_CYCLES, 10000, NOP cycles after reset release before PRECHARGE (≥1)
- TRP_CYCLES, 2, cycles from PRECHARGE to next command (≥1)
- TRFC_CYCLES, 7, cycles from AUTO REFRESH to next command (≥1)
- TMRD_CYCLES, 2, cycles from LOAD MODE to config_done (≥1)
- REFRESH_COUNT, 8, number of AUTO REFRESH commands (≥1)
- ADDR_WIDTH, 13, SDRAM address bus width (≥11)
- MODE_REG, 13'h020, value driven on addr during LOAD MODE (CL2, burst 1, sequential)

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- s_cke  output  1  SDRAM clock enable
- s_cs_n  output  1  chip select
- s_ras_n  output  1  row address strobe
- s_cas_n  output  1  column address strobe
- s_we_n  output  1  write enable
- s_ba  output  2  bank address
- s_addr  output  ADDR_WIDTH  address bus
- s_dqm  output  2  byte masks
- init_busy  output  1  sequence in progress
- config_done  output  1  initialisation complete (sticky until reset)

Behaviour:
- All outputs are registered. Single clock. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP = 0111
  - PRECHARGE = 0010
  - AUTO REFRESH = 0001
  - LOAD MODE = 0000
- Reset values:
  - s_cke=0
  - command=NOP
  - s_ba=0, s_addr=0
  - s_dqm=2'b11
  - init_busy=1, config_done=0
  - state=POWERUP
  - counter=POWERUP_CYCLES-1, refresh counter=0
- Edge numbering: edge 1 is the first rising edge that samples reset_n=1. "Cmd at edge N" means the command is on the outputs after edge N, held for exactly one cycle, then NOP.
- States:
  - POWERUP: s_cke=1 from edge 1. NOP. Counter decrements each edge; on reaching 0, go to PRECHARGE.
  - PRECHARGE: PRECHARGE ALL at edge P=POWERUP_CYCLES+1, with s_addr[10]=1 and other address bits and s_ba=0. Load counter TRP_CYCLES-1, go to WAIT_TRP.
  - WAIT_TRP: NOP until counter 0, then go to REFRESH. If TRP_CYCLES=1, go straight to REFRESH with no wait cycles.
  - REFRESH: AUTO REFRESH with s_addr=0. Increment refresh counter, load TRFC_CYCLES-1, go to WAIT_TRFC.
  - WAIT_TRFC: NOP until counter 0. Then go to REFRESH if fewer than REFRESH_COUNT refreshes have been issued, else LOAD_MODE.
  - LOAD_MODE: LOAD MODE with s_addr=MODE_REG, s_ba=0. Load TMRD_CYCLES-1, go to WAIT_TMRD.
  - WAIT_TMRD: NOP until counter 0, then go to DONE.
  - DONE: config_done=1, init_busy=0, NOP, s_dqm=0, s_cke=1. Stays here until reset.
- Command edges:
  - PRECHARGE at P
  - refresh i (0-based) at P+TRP_CYCLES+i·TRFC_CYCLES
  - LOAD MODE at L=P+TRP_CYCLES+REFRESH_COUNT·TRFC_CYCLES
  - config_done rises after edge L+TMRD_CYCLES
- Exactly one non-NOP command in any cycle. No command is issued before edge P.
- Counter width is $clog2 of the largest of (POWERUP_CYCLES, TRP_CYCLES, TRFC_CYCLES, TMRD_CYCLES), minimum 1. The refresh counter is $clog2(REFRESH_COUNT+1) wide. No wrap is possible.
- init_busy = !config_done at all times.
- Reset mid-sequence or in DONE: all outputs return to reset values on that edge (config_done drops, s_cke=0). The full sequence restarts from POWERUP after release.

Test Plan:
- Parameters POWERUP=20, TRP=2, TRFC=7, REFRESH=2, TMRD=2; release reset -> PRECHARGE at edge 21 with addr[10]=1; REFRESH at 23 and 30; LOAD MODE at 37 with addr=13'h020; config_done=1 from edge 39; NOP on every other edge.
- Same parameters; check every cycle edges 1..45 -> exactly one non-NOP command per listed edge; s_cke=0 only while in reset; s_dqm=11 until config_done, 00 after.
- All timing parameters =1, REFRESH=1 -> PRECHARGE at edge 2, REFRESH at 3, LOAD MODE at 4, config_done at 5.
- Assert reset_n=0 at edge 30 (mid-refresh) for 3 cycles, then release -> outputs at reset values during reset; sequence restarts, PRECHARGE 21 edges after release.
- Reset during DONE -> config_done drops on the reset edge, then re-rises at the same relative edge (39) after release.
- Default parameters -> PRECHARGE at edge 10001; 8 refreshes spaced 7 apart; config_done at edge 10061.
